multi_cycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS datapath. It sequences one instruction at a time through FETCH / DECODE / EXEC / MEM / WB over the shared ALU, register file and memory ports.
- Decodes the same instruction subset as the single-cycle decoder: addu, subu, ori, lw, sw, beq, lui, j, jal, jr.
- Adds wait-state handshakes to instruction memory and data memory.
- Sits between the IR, the datapath muxes and enables, and the memories.

---
 rtl/mips_defs_pkg.sv | 65 ++++++
 rtl/instr_class_dec.sv | 37 +++
 rtl/multi_cycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes,
// function codes, ALU operations and datapath mux selects.
package mips_defs;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [4:0] RA_REG = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_NOP  = 6'b000000;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_LUI = 4'd4;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] TO_REG_ALU = 2'd0;
  localparam logic [1:0] TO_REG_MEM = 2'd1;
  localparam logic [1:0] TO_REG_PC  = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } instr_flags_t;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational instruction classifier: op/func to one-hot class flags.
// An encoding matching no class is reported as not legal.
module instr_class_dec
  import mips_defs::*;
(
  input  logic [5:0]   i_op,
  input  logic [5:0]   i_func,
  output instr_flags_t o_flags,
  output logic         o_legal
);

  always_comb begin
    o_flags = '0;
    case (i_op)
      OP_RTYPE: begin
        // sll $0,$0,0 (all zeros) is accepted as a nop
        case (i_func)
          F_ADDU:  o_flags.addu = 1'b1;
          F_SUBU:  o_flags.subu = 1'b1;
          F_JR:    o_flags.jr   = 1'b1;
          F_NOP:   o_flags.nop  = 1'b1;
          default: o_flags      = '0;
        endcase
      end
      OP_ORI:  o_flags.ori = 1'b1;
      OP_LUI:  o_flags.lui = 1'b1;
      OP_LW:   o_flags.lw  = 1'b1;
      OP_SW:   o_flags.sw  = 1'b1;
      OP_BEQ:  o_flags.beq = 1'b1;
      OP_J:    o_flags.j   = 1'b1;
      OP_JAL:  o_flags.jal = 1'b1;
      default: o_flags     = '0;
    endcase
    o_legal = |o_flags;
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with
// wait states on instruction and data memory ready handshakes.
module multi_cycle_ctrl
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] to_reg,
  output logic       alu_src,
  output logic [1:0] ext_sel,
  output logic [3:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state_o
);

  state_t       r_state;
  state_t       w_next;
  instr_flags_t w_flags;
  logic         w_legal;

  logic       w_irWrite;
  logic       w_pcWrite;
  logic       w_regWrite;
  logic       w_memRead;
  logic       w_memWrite;
  logic       w_retire;
  logic       w_illegal;
  logic       w_clsAluSrc;
  logic [1:0] w_clsExtSel;
  logic [3:0] w_clsAluOp;

  instr_class_dec u_dec (
    .i_op    (op),
    .i_func  (func),
    .o_flags (w_flags),
    .o_legal (w_legal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // ALU setup per class; reused by EXEC, MEM_RD and WB so the result stays stable.
  always_comb begin
    w_clsAluSrc = 1'b0;
    w_clsExtSel = EXT_ZERO;
    w_clsAluOp  = ALU_ADD;
    if (w_flags.subu || w_flags.beq) w_clsAluOp = ALU_SUB;
    if (w_flags.ori) begin
      w_clsAluSrc = 1'b1;
      w_clsAluOp  = ALU_OR;
    end
    if (w_flags.lui) begin
      w_clsAluSrc = 1'b1;
      w_clsAluOp  = ALU_LUI;
    end
    if (w_flags.lw || w_flags.sw) begin
      w_clsAluSrc = 1'b1;
      w_clsExtSel = EXT_SIGN;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_irWrite  = 1'b0;
    w_pcWrite  = 1'b0;
    w_regWrite = 1'b0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    pc_src     = PC_SEQ;
    reg_dst    = REG_DST_RT;
    to_reg     = TO_REG_ALU;
    alu_src    = 1'b0;
    ext_sel    = EXT_ZERO;
    alu_op     = ALU_ADD;

    case (r_state)
      S_FETCH: begin
        w_irWrite = imem_ready;
        w_pcWrite = imem_ready;
        if (imem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = S_EXEC;
        if (w_flags.j || w_flags.jal) begin
          w_pcWrite = 1'b1;
          pc_src    = PC_JUMP;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
          // jal links on the same edge; the PC still holds PC+4
          if (w_flags.jal) begin
            w_regWrite = 1'b1;
            reg_dst    = REG_DST_RA;
            to_reg     = TO_REG_PC;
          end
        end else if (w_flags.jr) begin
          w_pcWrite = 1'b1;
          pc_src    = PC_REG;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end else if (!w_legal || w_flags.nop) begin
          w_illegal = !w_legal;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src = w_clsAluSrc;
        ext_sel = w_clsExtSel;
        alu_op  = w_clsAluOp;
        if (w_flags.beq) begin
          pc_src    = PC_BRANCH;
          w_pcWrite = zero;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end else if (w_flags.lw) begin
          w_next = S_MEM_RD;
        end else if (w_flags.sw) begin
          w_next = S_MEM_WR;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM_RD: begin
        w_memRead = 1'b1;
        alu_src   = w_clsAluSrc;
        ext_sel   = w_clsExtSel;
        alu_op    = w_clsAluOp;
        if (dmem_ready) w_next = S_WB;
      end
      S_MEM_WR: begin
        w_memWrite = 1'b1;
        if (dmem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_WB: begin
        w_regWrite = 1'b1;
        w_retire   = 1'b1;
        alu_src    = w_clsAluSrc;
        ext_sel    = w_clsExtSel;
        alu_op     = w_clsAluOp;
        reg_dst    = (w_flags.addu || w_flags.subu) ? REG_DST_RD : REG_DST_RT;
        to_reg     = w_flags.lw ? TO_REG_MEM : TO_REG_ALU;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are forced low for the whole reset window, not just after the state clears.
  assign ir_write  = w_irWrite  & reset_n;
  assign pc_write  = w_pcWrite  & reset_n;
  assign reg_write = w_regWrite & reset_n;
  assign mem_read  = w_memRead  & reset_n;
  assign mem_write = w_memWrite & reset_n;
  assign retire    = w_retire   & reset_n;
  assign illegal   = w_illegal  & reset_n;
  assign state_o   = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-instruction stage routes drive
// a behavioural model compared every cycle, plus literal latency/count checks.
module tb_multi_cycle_ctrl;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_NOP, C_ILL
  } cls_t;

  typedef struct packed {
    logic       irW;
    logic       pcW;
    logic [1:0] pcSrc;
    logic       regW;
    logic [1:0] regDst;
    logic [1:0] toReg;
    logic       aluSrc;
    logic [1:0] ext;
    logic [3:0] aluOp;
    logic       memR;
    logic       memW;
    logic       retire;
    logic       illegal;
    logic [2:0] st;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] to_reg;
  logic       alu_src;
  logic [1:0] ext_sel;
  logic [3:0] alu_op;
  logic       mem_read;
  logic       mem_write;
  logic       retire;
  logic       illegal;
  logic [2:0] state_o;

  int   checks   = 0;
  int   failures = 0;
  cls_t curCls   = C_NOP;
  int   mPos     = 0;
  int   mNext    = 0;
  int   cntMemRd, cntMemWr, cntRegWr, cntPcWr, cntIllegal, cntRetire;

  multi_cycle_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .func       (func),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .to_reg     (to_reg),
    .alu_src    (alu_src),
    .ext_sel    (ext_sel),
    .alu_op     (alu_op),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .retire     (retire),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // I-type "func" bits are immediate bits; odd values check they are ignored.
  function automatic logic [11:0] encodeInstr(input cls_t cls);
    case (cls)
      C_ADDU:  return {6'b000000, 6'b100001};
      C_SUBU:  return {6'b000000, 6'b100011};
      C_ORI:   return {6'b001101, 6'b001000};
      C_LUI:   return {6'b001111, 6'b000000};
      C_LW:    return {6'b100011, 6'b100001};
      C_SW:    return {6'b101011, 6'b000100};
      C_BEQ:   return {6'b000100, 6'b000011};
      C_J:     return {6'b000010, 6'b100001};
      C_JAL:   return {6'b000011, 6'b010000};
      C_JR:    return {6'b000000, 6'b001000};
      C_ILL:   return {6'b111111, 6'b000000};
      default: return 12'd0;
    endcase
  endfunction

  // Route = ordered list of stages an instruction visits (stage numbers as state_o reports them).
  function automatic int routeLen(input cls_t cls);
    case (cls)
      C_J, C_JAL, C_JR, C_NOP, C_ILL: return 2;
      C_BEQ:                          return 3;
      C_LW:                           return 5;
      default:                        return 4;
    endcase
  endfunction

  function automatic int routeStage(input cls_t cls, input int pos);
    if (pos < 3) return pos;
    if (pos == 3) return (cls == C_LW) ? 3 : (cls == C_SW) ? 4 : 5;
    return 5;
  endfunction

  function automatic logic stageDone(input int stage, input logic imemIn, input logic dmemIn);
    if (stage == 0) return imemIn;
    if (stage == 3 || stage == 4) return dmemIn;
    return 1'b1;
  endfunction

  function automatic logic [6:0] aluSettings(input cls_t cls);
    case (cls)
      C_SUBU, C_BEQ: return {1'b0, 2'd0, 4'd1};
      C_ORI:         return {1'b1, 2'd0, 4'd2};
      C_LUI:         return {1'b1, 2'd0, 4'd4};
      C_LW, C_SW:    return {1'b1, 2'd1, 4'd0};
      default:       return 7'd0;
    endcase
  endfunction

  function automatic exp_t modelOut(input int stage, input cls_t cls, input logic zeroIn,
                                    input logic imemIn, input logic dmemIn,
                                    input logic rstn, input logic last);
    exp_t e;
    e = '0;
    if (!rstn) return e;
    e.st = stage[2:0];
    case (stage)
      0: begin
        e.irW = imemIn;
        e.pcW = imemIn;
      end
      1: begin
        case (cls)
          C_J:   begin e.pcW = 1'b1; e.pcSrc = 2'd2; end
          C_JAL: begin
            e.pcW = 1'b1; e.pcSrc = 2'd2; e.regW = 1'b1; e.regDst = 2'd2; e.toReg = 2'd2;
          end
          C_JR:  begin e.pcW = 1'b1; e.pcSrc = 2'd3; end
          C_ILL: e.illegal = 1'b1;
          default: ;
        endcase
      end
      2: begin
        {e.aluSrc, e.ext, e.aluOp} = aluSettings(cls);
        if (cls == C_BEQ) begin
          e.pcSrc = 2'd1;
          e.pcW   = zeroIn;
        end
      end
      3: begin
        e.memR = 1'b1;
        {e.aluSrc, e.ext, e.aluOp} = aluSettings(cls);
      end
      4: e.memW = 1'b1;
      5: begin
        e.regW   = 1'b1;
        e.regDst = (cls == C_ADDU || cls == C_SUBU) ? 2'd1 : 2'd0;
        e.toReg  = (cls == C_LW) ? 2'd1 : 2'd0;
        {e.aluSrc, e.ext, e.aluOp} = aluSettings(cls);
      end
      default: ;
    endcase
    e.retire = last & stageDone(stage, imemIn, dmemIn);
    return e;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int   stage;
    logic last;
    exp_t e;
    stage = routeStage(curCls, mPos);
    last  = (mPos == routeLen(curCls) - 1);
    e     = modelOut(stage, curCls, zero, imem_ready, dmem_ready, reset_n, last);
    checkOutput("state_o",   int'(state_o),   int'(e.st));
    checkOutput("ir_write",  int'(ir_write),  int'(e.irW));
    checkOutput("pc_write",  int'(pc_write),  int'(e.pcW));
    checkOutput("pc_src",    int'(pc_src),    int'(e.pcSrc));
    checkOutput("reg_write", int'(reg_write), int'(e.regW));
    checkOutput("reg_dst",   int'(reg_dst),   int'(e.regDst));
    checkOutput("to_reg",    int'(to_reg),    int'(e.toReg));
    checkOutput("alu_src",   int'(alu_src),   int'(e.aluSrc));
    checkOutput("ext_sel",   int'(ext_sel),   int'(e.ext));
    checkOutput("alu_op",    int'(alu_op),    int'(e.aluOp));
    checkOutput("mem_read",  int'(mem_read),  int'(e.memR));
    checkOutput("mem_write", int'(mem_write), int'(e.memW));
    checkOutput("retire",    int'(retire),    int'(e.retire));
    checkOutput("illegal",   int'(illegal),   int'(e.illegal));
    if (!reset_n)
      mNext = 0;
    else if (stageDone(stage, imem_ready, dmem_ready))
      mNext = last ? 0 : mPos + 1;
    else
      mNext = mPos;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mPos <= 0;
    else          mPos <= mNext;
  end

  // Runs one instruction; ready inputs are low for the first N cycles of it.
  task automatic applyStimulus(input string name, input cls_t cls, input int imemLow,
                               input int dmemLow, input logic zeroIn, input int abortAt,
                               output int cyc);
    logic [11:0] enc;
    bit          finished;
    @(posedge clk);
    #1;
    enc        = encodeInstr(cls);
    curCls     = cls;
    op         = enc[11:6];
    func       = enc[5:0];
    zero       = zeroIn;
    cntMemRd   = 0;
    cntMemWr   = 0;
    cntRegWr   = 0;
    cntPcWr    = 0;
    cntIllegal = 0;
    cntRetire  = 0;
    cyc        = 1;
    finished   = 0;
    imem_ready = (cyc > imemLow);
    dmem_ready = (cyc > dmemLow);
    while (!finished && cyc <= 40) begin
      if (abortAt == cyc) begin
        checkOutput({name, "_preAbortMemWrite"}, int'(mem_write), 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput({name, "_abortMemWrite"}, int'(mem_write), 0);
        checkOutput({name, "_abortState"}, int'(state_o), 0);
        imem_ready = 1'b0;
        finished   = 1;
      end else begin
        @(negedge clk);
        cntMemRd   += int'(mem_read);
        cntMemWr   += int'(mem_write);
        cntRegWr   += int'(reg_write);
        cntPcWr    += int'(pc_write);
        cntIllegal += int'(illegal);
        cntRetire  += int'(retire);
        if (retire) begin
          finished = 1;
        end else begin
          @(posedge clk);
          #1;
          cyc++;
          imem_ready = (cyc > imemLow);
          dmem_ready = (cyc > dmemLow);
        end
      end
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_retire expected=retire_within_40", name);
    end
  endtask

  initial begin
    int c;
    reset_n    = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    op         = 6'd0;
    func       = 6'd0;
    zero       = 1'b0;
    #12;
    checkOutput("rst_state",   int'(state_o),  0);
    checkOutput("rst_irWrite", int'(ir_write), 0);
    checkOutput("rst_pcWrite", int'(pc_write), 0);
    repeat (2) @(negedge clk);
    imem_ready = 1'b0;
    #2 reset_n = 1'b1;

    applyStimulus("addu", C_ADDU, 0, 0, 1'b0, 0, c);
    checkOutput("addu_cycles", c, 4);
    checkOutput("addu_regWr", cntRegWr, 1);
    checkOutput("addu_retires", cntRetire, 1);
    applyStimulus("subu", C_SUBU, 0, 0, 1'b0, 0, c);
    checkOutput("subu_cycles", c, 4);
    applyStimulus("ori", C_ORI, 0, 0, 1'b1, 0, c);
    checkOutput("ori_cycles", c, 4);
    applyStimulus("lui", C_LUI, 0, 0, 1'b0, 0, c);
    checkOutput("lui_cycles", c, 4);

    applyStimulus("lwWait", C_LW, 0, 6, 1'b0, 0, c);
    checkOutput("lwWait_cycles", c, 8);
    checkOutput("lwWait_memRd", cntMemRd, 4);
    checkOutput("lwWait_memWr", cntMemWr, 0);
    checkOutput("lwWait_regWr", cntRegWr, 1);
    applyStimulus("lwFast", C_LW, 0, 0, 1'b0, 0, c);
    checkOutput("lwFast_cycles", c, 5);
    checkOutput("lwFast_memRd", cntMemRd, 1);

    applyStimulus("swFast", C_SW, 0, 0, 1'b0, 0, c);
    checkOutput("swFast_cycles", c, 4);
    checkOutput("swFast_memWr", cntMemWr, 1);
    checkOutput("swFast_regWr", cntRegWr, 0);
    applyStimulus("swWait", C_SW, 0, 5, 1'b0, 0, c);
    checkOutput("swWait_cycles", c, 6);
    checkOutput("swWait_memWr", cntMemWr, 3);

    applyStimulus("beqTaken", C_BEQ, 0, 0, 1'b1, 0, c);
    checkOutput("beqTaken_cycles", c, 3);
    checkOutput("beqTaken_pcWr", cntPcWr, 2);
    checkOutput("beqTaken_regWr", cntRegWr, 0);
    applyStimulus("beqNot", C_BEQ, 0, 0, 1'b0, 0, c);
    checkOutput("beqNot_cycles", c, 3);
    checkOutput("beqNot_pcWr", cntPcWr, 1);

    applyStimulus("jal", C_JAL, 0, 0, 1'b0, 0, c);
    checkOutput("jal_cycles", c, 2);
    checkOutput("jal_regWr", cntRegWr, 1);
    checkOutput("jal_pcWr", cntPcWr, 2);
    applyStimulus("j", C_J, 0, 0, 1'b0, 0, c);
    checkOutput("j_cycles", c, 2);
    checkOutput("j_regWr", cntRegWr, 0);
    applyStimulus("jr", C_JR, 0, 0, 1'b0, 0, c);
    checkOutput("jr_cycles", c, 2);
    checkOutput("jr_pcWr", cntPcWr, 2);

    applyStimulus("nop", C_NOP, 0, 0, 1'b0, 0, c);
    checkOutput("nop_cycles", c, 2);
    checkOutput("nop_illegal", cntIllegal, 0);
    checkOutput("nop_pcWr", cntPcWr, 1);

    applyStimulus("ill", C_ILL, 5, 0, 1'b0, 0, c);
    checkOutput("ill_cycles", c, 7);
    checkOutput("ill_illegal", cntIllegal, 1);
    checkOutput("ill_regWr", cntRegWr, 0);
    checkOutput("ill_pcWr", cntPcWr, 1);
    checkOutput("ill_retires", cntRetire, 1);

    applyStimulus("swAbort", C_SW, 0, 20, 1'b0, 5, c);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    applyStimulus("afterAbort", C_ADDU, 3, 0, 1'b0, 0, c);
    checkOutput("afterAbort_cycles", c, 7);
    checkOutput("afterAbort_regWr", cntRegWr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
